// File: rtl/int_core_pkg.sv
// Shared integer-core definitions: datapath widths and the writeback entry.
package int_core_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREG   = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/int_writeback_if.sv
// Result handshakes, issue notification and register-file write port of int_writeback.
interface int_writeback_if
   import int_core_pkg::*;
();

   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic              write_enable;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic [NREG-1:0]   pending;

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output issue_valid, issue_addr,
      input  alu_ready, mem_ready,
      input  write_enable, write_addr, write_data, pending
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  issue_valid, issue_addr,
      output alu_ready, mem_ready,
      output write_enable, write_addr, write_data, pending
   );

endinterface

// File: rtl/int_writeback_fifo.sv
// wb_fifo: two-write / one-read circular buffer of writeback entries.
module wb_fifo
   import int_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr0_en,
   input  wb_entry_t                wr0_entry,
   input  logic                     wr1_en,
   input  wb_entry_t                wr1_entry,
   input  logic                     rd_en,
   output wb_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       n_wr;
   logic             do_rd;
   wb_entry_t        first;

   // A lone wr1 takes the slot wr0 would have used, keeping entries contiguous.
   always_comb begin
      n_wr  = {1'b0, wr0_en} + {1'b0, wr1_en};
      first = wr0_en ? wr0_entry : wr1_entry;
      do_rd = rd_en && (count != '0);
   end

   always_ff @(posedge clock) begin
      if (wr0_en || wr1_en) mem[wr_ptr] <= first;
      if (wr0_en && wr1_en) mem[wr_ptr + PTR_W'(1)] <= wr1_entry;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_wr);
         rd_ptr <= rd_ptr + PTR_W'(do_rd);
         count  <= count + CNT_W'(n_wr) - CNT_W'(do_rd);
      end
   end

   assign head = mem[rd_ptr];
   assign free = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/int_writeback.sv
// Writeback serializer: merges ALU/memory results into one register-file write per cycle
// and tracks per-register outstanding writes for decode.
module int_writeback
   import int_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic           clock,
   input  logic           reset,
   int_writeback_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  free;
   logic              alu_rdy;
   logic              mem_rdy;
   logic              alu_enq;
   logic              mem_enq;
   logic              drain;
   wb_entry_t         alu_entry;
   wb_entry_t         mem_entry;
   wb_entry_t         head;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_n;

   // Readiness uses start-of-cycle free space; ALU owns the last slot.
   always_comb begin
      alu_rdy   = (free != '0);
      mem_rdy   = (free >= CNT_W'(2)) || ((free != '0) && !bus.alu_valid);
      alu_enq   = bus.alu_valid && alu_rdy && (bus.alu_addr != '0);
      mem_enq   = bus.mem_valid && mem_rdy && (bus.mem_addr != '0);
      alu_entry = '{addr: bus.alu_addr, data: bus.alu_data};
      mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};
      drain     = (count != '0);
   end

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr0_en    (alu_enq),
      .wr0_entry (alu_entry),
      .wr1_en    (mem_enq),
      .wr1_entry (mem_entry),
      .rd_en     (drain),
      .head      (head),
      .count     (count),
      .free      (free)
   );

   // Clear on the commit edge first so a same-edge issue to that register wins.
   always_comb begin
      pend_n = pend_q;
      if (we_q) pend_n[waddr_q] = 1'b0;
      if (bus.issue_valid && (bus.issue_addr != '0)) pend_n[bus.issue_addr] = 1'b1;
      pend_n[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         pend_q  <= '0;
      end else begin
         we_q   <= drain;
         pend_q <= pend_n;
         if (drain) begin
            waddr_q <= head.addr;
            wdata_q <= head.data;
         end
      end
   end

   assign bus.alu_ready    = alu_rdy;
   assign bus.mem_ready    = mem_rdy;
   assign bus.write_enable = we_q;
   assign bus.write_addr   = waddr_q;
   assign bus.write_data   = wdata_q;
   assign bus.pending      = pend_q;

endmodule

// File: tb/tb_int_writeback.sv
// Self-checking bench for int_writeback: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_int_writeback;
   import int_core_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int_writeback_if bus ();

   int_writeback #(
      .DEPTH(DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model state
   wb_entry_t         q[$];
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic [NREG-1:0]   m_pend;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_addr    = '0;
      bus.alu_data    = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_data    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_addr  = '0;
   endtask

   // Check outputs mid-cycle, advance the model across the coming edge, then return just after it.
   task automatic cycle();
      int        free;
      logic      e_ar, e_mr;
      wb_entry_t e;
      @(negedge clock);
      free = int'(DEPTH) - q.size();
      e_ar = (free >= 1);
      e_mr = (free >= 2) || (free >= 1 && !bus.alu_valid);
      chk("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
      chk("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
      chk("write_enable", 64'(bus.write_enable), 64'(m_we));
      chk("write_addr", 64'(bus.write_addr), 64'(m_addr));
      chk("write_data", bus.write_data, m_data);
      chk("pending", 64'(bus.pending), 64'(m_pend));
      if (!reset) begin
         q.delete();
         m_we   = 1'b0;
         m_addr = '0;
         m_data = '0;
         m_pend = '0;
      end else begin
         if (m_we) m_pend[m_addr] = 1'b0;
         if (bus.issue_valid && bus.issue_addr != 0) m_pend[bus.issue_addr] = 1'b1;
         if (q.size() > 0) begin
            e      = q.pop_front();
            m_we   = 1'b1;
            m_addr = e.addr;
            m_data = e.data;
         end else begin
            m_we = 1'b0;
         end
         if (bus.alu_valid && e_ar && bus.alu_addr != 0)
            q.push_back('{addr: bus.alu_addr, data: bus.alu_data});
         if (bus.mem_valid && e_mr && bus.mem_addr != 0)
            q.push_back('{addr: bus.mem_addr, data: bus.mem_data});
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_pend = '0;
      idle();
      reset = 1'b0;
      cycle();
      cycle();
      chk("rst_we", 64'(bus.write_enable), 64'd0);
      chk("rst_pending", 64'(bus.pending), 64'd0);
      chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
      reset = 1'b1;

      // single ALU result, two-edge latency
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'd5;
      bus.alu_data  = 64'hDEAD;
      cycle();
      idle();
      cycle();
      chk("t1_we", 64'(bus.write_enable), 64'd1);
      chk("t1_addr", 64'(bus.write_addr), 64'd5);
      chk("t1_data", bus.write_data, 64'hDEAD);
      cycle();
      chk("t1_we_off", 64'(bus.write_enable), 64'd0);

      // simultaneous ALU and memory results retire ALU first
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 64'd1;
      bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 64'd2;
      cycle();
      idle();
      cycle();
      chk("t2_first_addr", 64'(bus.write_addr), 64'd3);
      cycle();
      chk("t2_second_addr", 64'(bus.write_addr), 64'd4);
      chk("t2_second_data", bus.write_data, 64'd2);
      cycle();
      chk("t2_we_off", 64'(bus.write_enable), 64'd0);

      // sustained ALU stream: drain keeps pace
      for (int i = 0; i < 6; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = ADDR_W'(8 + i);
         bus.alu_data  = 64'(100 + i);
         #1;
         chk("t3_alu_ready", 64'(bus.alu_ready), 64'd1);
         cycle();
      end
      idle();
      repeat (3) cycle();

      // near-full: ALU gets the last slot, memory waits a cycle
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd10; bus.alu_data = 64'hA0;
      bus.mem_valid = 1'b1; bus.mem_addr = 5'd11; bus.mem_data = 64'hA1;
      cycle();
      bus.alu_addr = 5'd12; bus.alu_data = 64'hA2;
      bus.mem_addr = 5'd13; bus.mem_data = 64'hA3;
      cycle();
      bus.alu_addr = 5'd14; bus.alu_data = 64'hA4;
      bus.mem_addr = 5'd15; bus.mem_data = 64'hA5;
      #1;
      chk("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
      chk("t4_mem_ready_blocked", 64'(bus.mem_ready), 64'd0);
      cycle();
      bus.alu_valid = 1'b0;
      #1;
      chk("t4_mem_ready_later", 64'(bus.mem_ready), 64'd1);
      cycle();
      idle();
      repeat (5) cycle();

      // scoreboard around issue, retire and same-edge re-issue
      bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
      cycle();
      idle();
      chk("t5_pend_set", 64'(bus.pending[7]), 64'd1);
      cycle();
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 64'h77;
      cycle();
      idle();
      cycle();
      chk("t5_we", 64'(bus.write_enable), 64'd1);
      chk("t5_pend_before_commit", 64'(bus.pending[7]), 64'd1);
      bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
      cycle();
      idle();
      chk("t5_set_wins", 64'(bus.pending[7]), 64'd1);
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 64'h78;
      cycle();
      idle();
      cycle();
      chk("t5_pend_at_write", 64'(bus.pending[7]), 64'd1);
      cycle();
      chk("t5_pend_cleared", 64'(bus.pending[7]), 64'd0);

      // register 0 is accepted but never written or tracked
      bus.alu_valid = 1'b1; bus.alu_addr = '0; bus.alu_data = 64'h55;
      bus.mem_valid = 1'b1; bus.mem_addr = '0; bus.mem_data = 64'h66;
      bus.issue_valid = 1'b1; bus.issue_addr = '0;
      #1;
      chk("t6_zero_alu_ready", 64'(bus.alu_ready), 64'd1);
      chk("t6_zero_mem_ready", 64'(bus.mem_ready), 64'd1);
      cycle();
      idle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t6_zero_no_write", 64'(bus.write_enable), 64'd0);
         chk("t6_pend0", 64'(bus.pending[0]), 64'd0);
      end

      // fill, then reset mid-operation drops everything
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd20; bus.alu_data = 64'hB0;
      bus.mem_valid = 1'b1; bus.mem_addr = 5'd21; bus.mem_data = 64'hB1;
      cycle();
      bus.alu_addr = 5'd22; bus.mem_addr = 5'd23;
      bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
      cycle();
      bus.issue_valid = 1'b0;
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      idle();
      chk("t6_rst_we", 64'(bus.write_enable), 64'd0);
      chk("t6_rst_pending", 64'(bus.pending), 64'd0);
      chk("t6_rst_addr", 64'(bus.write_addr), 64'd0);
      chk("t6_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
      chk("t6_rst_mem_ready", 64'(bus.mem_ready), 64'd1);
      repeat (3) begin
         cycle();
         chk("t6_dropped", 64'(bus.write_enable), 64'd0);
      end

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 49) != 0);
         bus.alu_valid   = 1'($urandom_range(0, 1));
         bus.alu_addr    = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
         bus.alu_data    = {$urandom, $urandom};
         bus.mem_valid   = 1'($urandom_range(0, 1));
         bus.mem_addr    = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
         bus.mem_data    = {$urandom, $urandom};
         bus.issue_valid = 1'($urandom_range(0, 1));
         bus.issue_addr  = ADDR_W'($urandom_range(0, 31));
         cycle();
      end
      reset = 1'b1;
      idle();
      repeat (6) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
